// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bundle: pipeline stage operand/destination info in, stage enables and forwarding selects out.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    // ID stage
    logic [4:0]       rs1_id;
    logic [4:0]       rs2_id;
    logic             rs1_used_id;
    logic             rs2_used_id;
    // EX stage
    logic [4:0]       rs1_ex;
    logic [4:0]       rs2_ex;
    logic [4:0]       rd_ex;
    logic             load_ex;
    logic             branch_taken_ex;
    // MEM stage
    logic [4:0]       rd_mem;
    logic             reg_write_mem;
    logic             load_mem;
    logic             store_mem;
    logic             dmem_ready;
    // WB stage
    logic [4:0]       rd_wb;
    logic             reg_write_wb;
    // Controls
    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             flush_id;
    logic             flush_ex;
    logic             flush_wb;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             dmem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id,
        input  rs1_ex, rs2_ex, rd_ex, load_ex, branch_taken_ex,
        input  rd_mem, reg_write_mem, load_mem, store_mem, dmem_ready,
        input  rd_wb, reg_write_wb,
        output stall_if, stall_id, stall_ex, stall_mem,
        output flush_id, flush_ex, flush_wb,
        output fwd_a_sel, fwd_b_sel,
        output dmem_timeout, stall_cnt, flush_cnt
    );

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id,
        output rs1_ex, rs2_ex, rd_ex, load_ex, branch_taken_ex,
        output rd_mem, reg_write_mem, load_mem, store_mem, dmem_ready,
        output rd_wb, reg_write_wb,
        input  stall_if, stall_id, stall_ex, stall_mem,
        input  flush_id, flush_ex, flush_wb,
        input  fwd_a_sel, fwd_b_sel,
        input  dmem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: load-use stall,
// redirect flush, data-memory wait stall with timeout, EX forwarding, perf counters.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);
    // Wait counter must hold MEM_TIMEOUT; 5 bits covers timeouts up to 31.
    localparam int unsigned WCNT_W = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               dmem_timeout_q, dmem_timeout_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic               dmem_req_c;
    logic               mem_wait_c;
    logic               lu_c;
    logic               redirect_c;
    logic               stall_if_c, stall_id_c, stall_ex_c, stall_mem_c;
    logic               flush_id_c, flush_ex_c, flush_wb_c;
    logic [1:0]         fwd_a_c, fwd_b_c;

    // Hazard detection terms
    always_comb begin
        dmem_req_c = bus.load_mem | bus.store_mem;
        mem_wait_c = dmem_req_c & ~bus.dmem_ready;
        lu_c       = bus.load_ex & (bus.rd_ex != 5'd0) &
                     ((bus.rs1_used_id & (bus.rs1_id == bus.rd_ex)) |
                      (bus.rs2_used_id & (bus.rs2_id == bus.rd_ex)));
    end

    // Prioritised stall/flush enables; reset forces bubbles everywhere
    always_comb begin
        stall_if_c  = 1'b0;
        stall_id_c  = 1'b0;
        stall_ex_c  = 1'b0;
        stall_mem_c = 1'b0;
        flush_id_c  = 1'b0;
        flush_ex_c  = 1'b0;
        flush_wb_c  = 1'b0;
        redirect_c  = 1'b0;
        if (rst) begin
            flush_id_c = 1'b1;
            flush_ex_c = 1'b1;
            flush_wb_c = 1'b1;
        end else if ((state_q == ST_ERROR) || mem_wait_c) begin
            // Freeze everything upstream of WB; WB gets a bubble each cycle
            stall_if_c  = 1'b1;
            stall_id_c  = 1'b1;
            stall_ex_c  = 1'b1;
            stall_mem_c = 1'b1;
            flush_wb_c  = 1'b1;
        end else if (bus.branch_taken_ex) begin
            flush_id_c = 1'b1;
            flush_ex_c = 1'b1;
            redirect_c = 1'b1;
        end else if (lu_c) begin
            stall_if_c = 1'b1;
            stall_id_c = 1'b1;
            flush_ex_c = 1'b1;
        end
    end

    // EX operand forwarding, MEM (non-load) over WB
    always_comb begin
        fwd_a_c = 2'b00;
        fwd_b_c = 2'b00;
        if (!rst) begin
            if (bus.reg_write_mem && !bus.load_mem && (bus.rd_mem != 5'd0) &&
                (bus.rd_mem == bus.rs1_ex)) begin
                fwd_a_c = 2'b01;
            end else if (bus.reg_write_wb && (bus.rd_wb != 5'd0) &&
                         (bus.rd_wb == bus.rs1_ex)) begin
                fwd_a_c = 2'b10;
            end
            if (bus.reg_write_mem && !bus.load_mem && (bus.rd_mem != 5'd0) &&
                (bus.rd_mem == bus.rs2_ex)) begin
                fwd_b_c = 2'b01;
            end else if (bus.reg_write_wb && (bus.rd_wb != 5'd0) &&
                         (bus.rd_wb == bus.rs2_ex)) begin
                fwd_b_c = 2'b10;
            end
        end
    end

    // Memory-wait FSM next state, sticky timeout and counters
    always_comb begin
        state_d        = state_q;
        wcnt_d         = wcnt_q;
        dmem_timeout_d = dmem_timeout_q;
        stall_cnt_d    = stall_cnt_q + CNT_W'(stall_if_c);
        flush_cnt_d    = flush_cnt_q + CNT_W'(redirect_c);
        case (state_q)
            ST_RUN: begin
                if (mem_wait_c) begin
                    state_d = ST_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (bus.dmem_ready) begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) begin
                    state_d        = ST_ERROR;
                    dmem_timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            wcnt_q         <= '0;
            dmem_timeout_q <= 1'b0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            dmem_timeout_q <= dmem_timeout_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign bus.stall_if     = stall_if_c;
    assign bus.stall_id     = stall_id_c;
    assign bus.stall_ex     = stall_ex_c;
    assign bus.stall_mem    = stall_mem_c;
    assign bus.flush_id     = flush_id_c;
    assign bus.flush_ex     = flush_ex_c;
    assign bus.flush_wb     = flush_wb_c;
    assign bus.fwd_a_sel    = fwd_a_c;
    assign bus.fwd_b_sel    = fwd_b_c;
    assign bus.dmem_timeout = dmem_timeout_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_pipeline_ctrl;
    localparam int unsigned MEM_TIMEOUT = 16;
    localparam int unsigned CNT_W       = 32;

    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb}
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_FREEZE = 7'b1111001;
    localparam logic [6:0] C_REDIR  = 7'b0000110;
    localparam logic [6:0] C_LU     = 7'b1100010;
    localparam logic [6:0] C_RESET  = 7'b0000111;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ctrl_obs();
        return {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
                bus.flush_id, bus.flush_ex, bus.flush_wb};
    endfunction

    task automatic clear_inputs();
        bus.rs1_id = 5'd0; bus.rs2_id = 5'd0; bus.rs1_used_id = 1'b0; bus.rs2_used_id = 1'b0;
        bus.rs1_ex = 5'd0; bus.rs2_ex = 5'd0; bus.rd_ex = 5'd0; bus.load_ex = 1'b0;
        bus.branch_taken_ex = 1'b0;
        bus.rd_mem = 5'd0; bus.reg_write_mem = 1'b0; bus.load_mem = 1'b0; bus.store_mem = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.rd_wb = 5'd0; bus.reg_write_wb = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        // Hazard-looking inputs must not leak through while in reset
        bus.load_ex = 1'b1; bus.rd_ex = 5'd3; bus.rs1_id = 5'd3; bus.rs1_used_id = 1'b1;
        bus.branch_taken_ex = 1'b1; bus.load_mem = 1'b1;
        bus.reg_write_mem = 1'b1; bus.rd_mem = 5'd4; bus.rs1_ex = 5'd4;
        next_cycle();
        @(negedge clk);
        n_vec++;
        if (ctrl_obs() !== C_RESET) begin
            n_err++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl_obs(), C_RESET);
        end
        n_vec++;
        if ({bus.fwd_a_sel, bus.fwd_b_sel, bus.dmem_timeout} !== 5'b00000) begin
            n_err++; $display("FAIL reset_fwd_to got=%b exp=00000", {bus.fwd_a_sel, bus.fwd_b_sel, bus.dmem_timeout});
        end
        n_vec++;
        if (bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin
            n_err++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.stall_cnt, bus.flush_cnt);
        end
        next_cycle();
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        bus.load_ex = 1'b1; bus.rd_ex = 5'd5; bus.rs1_id = 5'd5; bus.rs1_used_id = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctrl_obs() !== C_LU) begin
            n_err++; $display("FAIL lu_rs1 got=%b exp=%b", ctrl_obs(), C_LU);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_vec++;
        if (ctrl_obs() !== C_NONE || bus.stall_cnt !== 32'd1) begin
            n_err++; $display("FAIL lu_release got=%b cnt=%0d exp=%b cnt=1", ctrl_obs(), bus.stall_cnt, C_NONE);
        end
        // rs2 path
        bus.load_ex = 1'b1; bus.rd_ex = 5'd9; bus.rs2_id = 5'd9; bus.rs2_used_id = 1'b1;
        #1;
        n_vec++;
        if (ctrl_obs() !== C_LU) begin
            n_err++; $display("FAIL lu_rs2 got=%b exp=%b", ctrl_obs(), C_LU);
        end
        // unused source or x0 destination do not stall
        bus.rs2_used_id = 1'b0;
        #1;
        n_vec++;
        if (ctrl_obs() !== C_NONE) begin
            n_err++; $display("FAIL lu_unused got=%b exp=%b", ctrl_obs(), C_NONE);
        end
        bus.rd_ex = 5'd0; bus.rs1_id = 5'd0; bus.rs1_used_id = 1'b1;
        #1;
        n_vec++;
        if (ctrl_obs() !== C_NONE) begin
            n_err++; $display("FAIL lu_x0 got=%b exp=%b", ctrl_obs(), C_NONE);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_branch_over_lu();
        do_reset();
        bus.load_ex = 1'b1; bus.rd_ex = 5'd5; bus.rs1_id = 5'd5; bus.rs1_used_id = 1'b1;
        bus.branch_taken_ex = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctrl_obs() !== C_REDIR) begin
            n_err++; $display("FAIL branch_lu got=%b exp=%b", ctrl_obs(), C_REDIR);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_vec++;
        if (bus.flush_cnt !== 32'd1 || bus.stall_cnt !== 32'd0) begin
            n_err++; $display("FAIL branch_lu_cnt got=%0d/%0d exp=1/0", bus.flush_cnt, bus.stall_cnt);
        end
        next_cycle();
    endtask

    task automatic test_mem_wait();
        do_reset();
        bus.load_mem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.dmem_ready = 1'b0;
            @(negedge clk);
            n_vec++;
            if (ctrl_obs() !== C_FREEZE) begin
                n_err++; $display("FAIL wait3_cyc%0d got=%b exp=%b", i, ctrl_obs(), C_FREEZE);
            end
            next_cycle();
        end
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctrl_obs() !== C_NONE) begin
            n_err++; $display("FAIL wait3_ready got=%b exp=%b", ctrl_obs(), C_NONE);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_vec++;
        if (bus.stall_cnt !== 32'd3 || bus.dmem_timeout !== 1'b0) begin
            n_err++; $display("FAIL wait3_cnt got=%0d to=%b exp=3 to=0", bus.stall_cnt, bus.dmem_timeout);
        end
        // Longest wait that still completes without a timeout
        do_reset();
        bus.store_mem = 1'b1;
        for (int i = 0; i < int'(MEM_TIMEOUT); i++) next_cycle();
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctrl_obs() !== C_NONE) begin
            n_err++; $display("FAIL wait_max_ready got=%b exp=%b", ctrl_obs(), C_NONE);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_vec++;
        if (bus.dmem_timeout !== 1'b0 || bus.stall_cnt !== CNT_W'(MEM_TIMEOUT)) begin
            n_err++; $display("FAIL wait_max got to=%b cnt=%0d exp to=0 cnt=%0d", bus.dmem_timeout, bus.stall_cnt, MEM_TIMEOUT);
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.load_mem = 1'b1;
        for (int i = 1; i <= int'(MEM_TIMEOUT) + 2; i++) begin
            @(negedge clk);
            n_vec++;
            if (ctrl_obs() !== C_FREEZE || bus.dmem_timeout !== (i >= int'(MEM_TIMEOUT) + 2)) begin
                n_err++; $display("FAIL timeout_cyc%0d got=%b to=%b exp=%b to=%b", i, ctrl_obs(),
                                  bus.dmem_timeout, C_FREEZE, (i >= int'(MEM_TIMEOUT) + 2));
            end
            next_cycle();
        end
        clear_inputs();
        bus.dmem_ready = 1'b1; bus.branch_taken_ex = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctrl_obs() !== C_FREEZE || bus.dmem_timeout !== 1'b1 ||
            bus.stall_cnt !== CNT_W'(MEM_TIMEOUT + 2) || bus.flush_cnt !== '0) begin
            n_err++; $display("FAIL error_sticky got=%b to=%b sc=%0d fc=%0d exp=%b to=1 sc=%0d fc=0",
                              ctrl_obs(), bus.dmem_timeout, bus.stall_cnt, bus.flush_cnt, C_FREEZE, MEM_TIMEOUT + 2);
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        n_vec++;
        if (ctrl_obs() !== C_NONE || bus.dmem_timeout !== 1'b0 ||
            bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin
            n_err++; $display("FAIL error_reset got=%b to=%b sc=%0d fc=%0d exp=%b to=0 sc=0 fc=0",
                              ctrl_obs(), bus.dmem_timeout, bus.stall_cnt, bus.flush_cnt, C_NONE);
        end
        next_cycle();
    endtask

    task automatic test_forwarding();
        do_reset();
        bus.dmem_ready = 1'b1;
        bus.rd_mem = 5'd7; bus.rd_wb = 5'd7; bus.rs1_ex = 5'd7; bus.rs2_ex = 5'd7;
        bus.reg_write_mem = 1'b1; bus.reg_write_wb = 1'b1;
        #1;
        n_vec++;
        if (bus.fwd_a_sel !== 2'b01 || bus.fwd_b_sel !== 2'b01) begin
            n_err++; $display("FAIL fwd_mem got=%b/%b exp=01/01", bus.fwd_a_sel, bus.fwd_b_sel);
        end
        bus.load_mem = 1'b1;
        #1;
        n_vec++;
        if (bus.fwd_a_sel !== 2'b10 || bus.fwd_b_sel !== 2'b10) begin
            n_err++; $display("FAIL fwd_wb got=%b/%b exp=10/10", bus.fwd_a_sel, bus.fwd_b_sel);
        end
        bus.rd_wb = 5'd0;
        #1;
        n_vec++;
        if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00) begin
            n_err++; $display("FAIL fwd_none got=%b/%b exp=00/00", bus.fwd_a_sel, bus.fwd_b_sel);
        end
        // Independent operands, forwarding unaffected by a stall
        bus.load_mem = 1'b0; bus.dmem_ready = 1'b0; bus.store_mem = 1'b1;
        bus.rd_wb = 5'd3; bus.rs2_ex = 5'd3;
        #1;
        n_vec++;
        if (bus.fwd_a_sel !== 2'b01 || bus.fwd_b_sel !== 2'b10 || ctrl_obs() !== C_FREEZE) begin
            n_err++; $display("FAIL fwd_split got=%b/%b ctrl=%b exp=01/10 ctrl=%b", bus.fwd_a_sel, bus.fwd_b_sel, ctrl_obs(), C_FREEZE);
        end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_branch_during_wait();
        do_reset();
        bus.load_mem = 1'b1; bus.branch_taken_ex = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_vec++;
            if (ctrl_obs() !== C_FREEZE || bus.flush_cnt !== '0) begin
                n_err++; $display("FAIL br_wait_cyc%0d got=%b fc=%0d exp=%b fc=0", i, ctrl_obs(), bus.flush_cnt, C_FREEZE);
            end
            next_cycle();
        end
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ctrl_obs() !== C_REDIR) begin
            n_err++; $display("FAIL br_wait_ready got=%b exp=%b", ctrl_obs(), C_REDIR);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_vec++;
        if (bus.flush_cnt !== 32'd1 || bus.stall_cnt !== 32'd2 || ctrl_obs() !== C_NONE) begin
            n_err++; $display("FAIL br_wait_cnt got fc=%0d sc=%0d ctrl=%b exp fc=1 sc=2 ctrl=%b",
                              bus.flush_cnt, bus.stall_cnt, ctrl_obs(), C_NONE);
        end
        next_cycle();
    endtask

    function automatic logic [1:0] ref_fwd(logic [4:0] rs);
        if (bus.reg_write_mem && !bus.load_mem && bus.rd_mem != 5'd0 && bus.rd_mem == rs) return 2'b01;
        if (bus.reg_write_wb && bus.rd_wb != 5'd0 && bus.rd_wb == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic test_random();
        // Model: length of the current unanswered memory wait (0 = not waiting) and an error latch
        int               waited;
        bit               err;
        logic [CNT_W-1:0] m_stall, m_flush;
        int               drought;
        bit               mw, lu;
        logic [6:0]       e_ctrl;
        logic [3:0]       e_fwd;
        do_reset();
        waited = 0; err = 1'b0; m_stall = '0; m_flush = '0; drought = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.rs1_id = 5'($urandom_range(0, 3)); bus.rs2_id = 5'($urandom_range(0, 3));
            bus.rs1_used_id = 1'($urandom); bus.rs2_used_id = 1'($urandom);
            bus.rs1_ex = 5'($urandom_range(0, 3)); bus.rs2_ex = 5'($urandom_range(0, 3));
            bus.rd_ex = 5'($urandom_range(0, 3)); bus.load_ex = ($urandom_range(0, 2) == 0);
            bus.branch_taken_ex = ($urandom_range(0, 4) == 0);
            bus.rd_mem = 5'($urandom_range(0, 3)); bus.reg_write_mem = 1'($urandom);
            bus.load_mem = ($urandom_range(0, 3) == 0); bus.store_mem = ($urandom_range(0, 5) == 0);
            bus.rd_wb = 5'($urandom_range(0, 3)); bus.reg_write_wb = 1'($urandom);
            if (drought == 0 && $urandom_range(0, 39) == 0) drought = $urandom_range(1, 20);
            if (drought > 0) begin
                bus.dmem_ready = 1'b0;
                drought--;
            end else begin
                bus.dmem_ready = ($urandom_range(0, 3) != 0);
            end

            mw = (bus.load_mem | bus.store_mem) & ~bus.dmem_ready;
            lu = bus.load_ex && bus.rd_ex != 5'd0 &&
                 ((bus.rs1_used_id && bus.rs1_id == bus.rd_ex) || (bus.rs2_used_id && bus.rs2_id == bus.rd_ex));
            if (rst)                      e_ctrl = C_RESET;
            else if (err || mw)           e_ctrl = C_FREEZE;
            else if (bus.branch_taken_ex) e_ctrl = C_REDIR;
            else if (lu)                  e_ctrl = C_LU;
            else                          e_ctrl = C_NONE;
            e_fwd = rst ? 4'b0000 : {ref_fwd(bus.rs1_ex), ref_fwd(bus.rs2_ex)};

            @(negedge clk);
            n_vec++;
            if (ctrl_obs() !== e_ctrl) begin
                n_err++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc, ctrl_obs(), e_ctrl);
            end
            n_vec++;
            if ({bus.fwd_a_sel, bus.fwd_b_sel} !== e_fwd) begin
                n_err++; $display("FAIL rnd_fwd cyc=%0d got=%b exp=%b", cyc, {bus.fwd_a_sel, bus.fwd_b_sel}, e_fwd);
            end
            n_vec++;
            if (bus.dmem_timeout !== err || bus.stall_cnt !== m_stall || bus.flush_cnt !== m_flush) begin
                n_err++; $display("FAIL rnd_state cyc=%0d got to=%b sc=%0d fc=%0d exp to=%b sc=%0d fc=%0d",
                                  cyc, bus.dmem_timeout, bus.stall_cnt, bus.flush_cnt, err, m_stall, m_flush);
            end

            if (rst) begin
                waited = 0; err = 1'b0; m_stall = '0; m_flush = '0;
            end else begin
                m_stall = m_stall + CNT_W'(e_ctrl[6]);
                m_flush = m_flush + CNT_W'(e_ctrl == C_REDIR);
                if (!err) begin
                    if (waited > 0) begin
                        if (bus.dmem_ready)               waited = 0;
                        else if (waited == MEM_TIMEOUT) err = 1'b1;
                        else                              waited++;
                    end else if (mw) begin
                        waited = 1;
                    end
                end
            end
            next_cycle();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        clear_inputs();
        next_cycle();
        test_reset();
        test_load_use();
        test_branch_over_lu();
        test_mem_wait();
        test_timeout();
        test_forwarding();
        test_branch_during_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Hazard and sequencing controller for the 5-stage RV32I pipeline. It drives the hold and clear enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the EX-stage forwarding selects. It resolves load-use, taken-branch/jump redirect and multi-cycle data-memory wait hazards, detects data-memory timeouts, and keeps stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive data-memory wait cycles before error (≥1)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
rs1_id  in  5  rs1 of instruction in ID
rs2_id  in  5  rs2 of instruction in ID
rs1_used_id  in  1  ID instruction reads rs1
rs2_used_id  in  1  ID instruction reads rs2
rs1_ex  in  5  rs1 of instruction in EX
rs2_ex  in  5  rs2 of instruction in EX
rd_ex  in  5  destination in EX
load_ex  in  1  EX instruction is a load
branch_taken_ex  in  1  EX resolved redirect (taken branch/jal/jalr)
rd_mem  in  5  destination in MEM
reg_write_mem  in  1  MEM instruction writes RF
load_mem  in  1  MEM instruction is a load
store_mem  in  1  MEM instruction is a store
dmem_ready  in  1  data memory completes access this cycle
rd_wb  in  5  destination in WB
reg_write_wb  in  1  WB instruction writes RF
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
stall_ex  out  1  hold ID/EX
stall_mem  out  1  hold EX/MEM
flush_id  out  1  clear IF/ID to bubble
flush_ex  out  1  clear ID/EX to bubble
flush_wb  out  1  clear MEM/WB to bubble
fwd_a_sel  out  2  EX operand A: 00 RF, 01 MEM ALU result, 10 WB data
fwd_b_sel  out  2  EX operand B, same encoding
dmem_timeout  out  1  sticky error flag
stall_cnt  out  CNT_W  cycles with stall_if=1
flush_cnt  out  CNT_W  branch redirect flushes

Behaviour:
- dmem_req = load_mem | store_mem; mem_wait = dmem_req & ~dmem_ready.
- Load-use: lu = load_ex & rd_ex!=0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
- FSM states: RUN, WAIT, ERROR; 5-bit wait counter wcnt.
  - RUN: if mem_wait, go to WAIT with wcnt=1; else stay.
  - WAIT: if dmem_ready, go to RUN with wcnt=0. Else if wcnt==MEM_TIMEOUT, go to ERROR. Else wcnt+1.
  - ERROR: absorbing until rst. dmem_timeout=1, registered on entry.
- Control outputs are combinational from the state and inputs, with the priority below (highest first):
  1. ERROR: all stall_*=1; flush_id=flush_ex=0; flush_wb=1. The pipeline is frozen.
  2. mem_wait (RUN or WAIT): all stall_*=1; flush_wb=1; flush_id=flush_ex=0. branch_taken_ex and lu are ignored this cycle; they re-evaluate when the stall releases because ID/EX is held.
  3. branch_taken_ex: flush_id=flush_ex=1; all stalls 0. This overrides lu, since the dependent instruction is squashed.
  4. lu: stall_if=stall_id=1; flush_ex=1; stall_ex=stall_mem=0; flush_wb=0. The stall lasts exactly 1 cycle per load.
  5. Otherwise all outputs are 0.
- In the dmem_ready completion cycle the pipeline advances: no memory stall is asserted, and priorities 3–5 apply.
- Forwarding is combinational and independent of stalls:
  - fwd_a_sel=01 if reg_write_mem & ~load_mem & rd_mem!=0 & rd_mem==rs1_ex.
  - Else fwd_a_sel=10 if reg_write_wb & rd_wb!=0 & rd_wb==rs1_ex.
  - Else fwd_a_sel=00.
  - fwd_b_sel is the same using rs2_ex.
  - MEM has priority over WB.
- Counters:
  - stall_cnt increments every cycle stall_if=1, ERROR included.
  - flush_cnt increments on each cycle priority 3 is active.
  - Both wrap modulo 2^CNT_W.
- Reset, while rst=1:
  - Sequential values: state=RUN, wcnt=0, dmem_timeout=0, stall_cnt=flush_cnt=0.
  - Outputs forced: all stall_*=0, flush_id=flush_ex=flush_wb=1, fwd_*_sel=00.
  - Reset mid-WAIT or in ERROR returns to RUN on the next edge.

Test Plan:
- Load-use: load_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 -> one cycle of stall_if=stall_id=flush_ex=1; stall_cnt=1.
- Branch plus load-use in the same cycle: branch_taken_ex=1 with lu true -> flush_id=flush_ex=1, stalls 0, flush_cnt=1.
- Memory wait: load_mem=1, dmem_ready low for 3 cycles then high -> all stalls and flush_wb high for exactly 3 cycles, released on the ready cycle; stall_cnt=3.
- Timeout: dmem_req held with dmem_ready=0 for MEM_TIMEOUT+2 cycles -> dmem_timeout=1 and stays, all stalls stuck at 1; rst clears to RUN with counters 0.
- Forwarding: rd_mem=rd_wb=rs1_ex=7, both writes set -> fwd_a_sel=01. Set load_mem=1 -> fwd_a_sel=10. Set rd_wb=0 and load_mem=1 -> fwd_a_sel=00.
- Branch during memory wait: branch_taken_ex=1 while mem_wait -> no flush and flush_cnt unchanged until the ready cycle, then flush_id=flush_ex=1 once.
